// File: rtl/div8_pkg.sv
// div8_pkg
// Shared definitions for the 8088 byte-divide datapath: the sequencer step
// numbers that trigger each datapath action, the operand widths, the signed
// quotient limit, the datapath phase enum and a two's complement helper.
// Optional feature macro: DIV8_SIGNED_EN (enables IDIV handling in the top).
package div8_pkg;

  // Sequencer step indices acted upon by the datapath
  localparam logic [3:0] T_LOAD       = 4'd1;
  localparam logic [3:0] T_ITER_FIRST = 4'd2;
  localparam logic [3:0] T_ITER_LAST  = 4'd9;
  localparam logic [3:0] T_FIX        = 4'd10;
  localparam logic [3:0] T_WB         = 4'd11;

  // Operand widths: AX dividend, r/m8 divisor, partial remainder with carry bit
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int REM_W      = 9;

  // Largest quotient magnitude IDIV accepts (range is -127..+127)
  localparam logic [DIVISOR_W-1:0] Q_LIMIT = 8'd127;

  // Datapath phase: idle between operations, busy from load to writeback
  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_BUSY = 1'b1
  } phase_e;

  // Two's complement negation of a byte
  function automatic logic [DIVISOR_W-1:0] negate8(input logic [DIVISOR_W-1:0] value);
    return ~value + 8'd1;
  endfunction

endpackage

// File: rtl/div8_step_datapath_if.sv
// div8_step_datapath_if
// Bundles the sequencer-facing signals of the byte-divide datapath.
//   master : the divide sequencer (drives STEP/FIN and the operands)
//   slave  : the datapath (drives QUO/REM/DERR/DONE/BUSY)
// Signals:
//   STEP[3:0]       sequencer step index, changes on negedge
//   FIN             sequencer idle flag, high only in T0
//   IS_SIGNED       1 = IDIV, 0 = DIV, sampled at T1
//   DIVIDEND[15:0]  AX operand, sampled at T1
//   DIVISOR[7:0]    r/m8 operand, sampled at T1
//   QUO[7:0]        quotient (AL)
//   REM[7:0]        remainder (AH)
//   DERR            divide error, valid with DONE
//   DONE            one-cycle completion pulse
//   BUSY            operation in progress
interface div8_step_datapath_if;
  import div8_pkg::*;

  logic [3:0]            STEP;
  logic                  FIN;
  logic                  IS_SIGNED;
  logic [DIVIDEND_W-1:0] DIVIDEND;
  logic [DIVISOR_W-1:0]  DIVISOR;
  logic [DIVISOR_W-1:0]  QUO;
  logic [DIVISOR_W-1:0]  REM;
  logic                  DERR;
  logic                  DONE;
  logic                  BUSY;

  modport master (
    output STEP, FIN, IS_SIGNED, DIVIDEND, DIVISOR,
    input  QUO, REM, DERR, DONE, BUSY
  );

  modport slave (
    input  STEP, FIN, IS_SIGNED, DIVIDEND, DIVISOR,
    output QUO, REM, DERR, DONE, BUSY
  );

endinterface

// File: rtl/div8_restore_step.sv
// div8_restore_step
// One combinational restoring-division iteration. Shifts the top quotient
// bit into the partial remainder, trial-subtracts the divisor and, when the
// subtraction fits, keeps the difference and sets the new quotient LSB.
// Ports:
//   rem_i[8:0]      current partial remainder
//   quo_i[7:0]      current partial quotient (dividend low bits shifting out)
//   divisor_i[7:0]  divisor magnitude
//   rem_o[8:0]      partial remainder after this iteration
//   quo_o[7:0]      partial quotient after this iteration
module div8_restore_step
  import div8_pkg::*;
(
  input  logic [REM_W-1:0]     rem_i,
  input  logic [DIVISOR_W-1:0] quo_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [REM_W-1:0]     rem_o,
  output logic [DIVISOR_W-1:0] quo_o
);

  logic [REM_W-1:0] trial;
  logic             unusedRemMsb;

  // The remainder stays below the divisor between iterations, so its carry
  // bit never reaches the shifted trial value.
  assign unusedRemMsb = rem_i[REM_W-1];

  // Shift, compare against the zero-extended divisor, restore on failure
  always_comb begin
    trial = {rem_i[DIVISOR_W-1:0], quo_i[DIVISOR_W-1]};
    quo_o = {quo_i[DIVISOR_W-2:0], 1'b0};
    rem_o = trial;
    if (trial >= {1'b0, divisor_i}) begin
      rem_o    = trial - {1'b0, divisor_i};
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div8_step_datapath.sv
// div8_step_datapath
// Restoring-division datapath for the 8088 DIV/IDIV r/m8 byte divide. It
// follows the divide sequencer's step index and performs one action per
// rising edge: load at T1, eight restoring iterations T2..T9, sign fixup at
// T10 and writeback with a DONE pulse at T11. A divide error leaves QUO/REM
// untouched and raises DERR.
// Optional feature macro: DIV8_SIGNED_EN -- when defined, IDIV is supported
// (magnitude conversion, sign fixup, -127..+127 quotient check); otherwise
// IS_SIGNED is ignored and every operation is unsigned.
// Ports:
//   CLK   clock, all state updates on posedge
//   RST   asynchronous active-high reset
//   bus   div8_step_datapath_if.slave: STEP, FIN, IS_SIGNED, DIVIDEND,
//         DIVISOR in; QUO, REM, DERR, DONE, BUSY out
module div8_step_datapath
  import div8_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  div8_step_datapath_if.slave  bus
);

  phase_e                phase_q, phase_d;
  logic [REM_W-1:0]      partRem_q, partRem_d;
  logic [DIVISOR_W-1:0]  partQuo_q, partQuo_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic                  err_q, err_d;
  logic [DIVISOR_W-1:0]  quoOut_q, quoOut_d;
  logic [DIVISOR_W-1:0]  remOut_q, remOut_d;
  logic                  derr_q, derr_d;
  logic                  done_q, done_d;

  logic [DIVIDEND_W-1:0] dividendMag;
  logic [DIVISOR_W-1:0]  divisorMag;
  logic [REM_W-1:0]      stepRem;
  logic [DIVISOR_W-1:0]  stepQuo;
  logic                  inIterWindow;

`ifdef DIV8_SIGNED_EN
  logic                  signedOp_q, signedOp_d;
  logic                  negQuo_q, negQuo_d;
  logic                  negRem_q, negRem_d;

  // IDIV works on magnitudes; the signs are remembered for the T10 fixup
  always_comb begin
    dividendMag = bus.DIVIDEND;
    divisorMag  = bus.DIVISOR;
    if (bus.IS_SIGNED && bus.DIVIDEND[DIVIDEND_W-1]) begin
      dividendMag = ~bus.DIVIDEND + 16'd1;
    end
    if (bus.IS_SIGNED && bus.DIVISOR[DIVISOR_W-1]) begin
      divisorMag = negate8(bus.DIVISOR);
    end
  end
`else
  logic                  unusedIsSigned;

  // Unsigned-only build: the operands are already magnitudes
  assign unusedIsSigned = bus.IS_SIGNED;
  always_comb begin
    dividendMag = bus.DIVIDEND;
    divisorMag  = bus.DIVISOR;
  end
`endif

  // Single iteration unit shared by all eight iteration steps
  div8_restore_step uStep (
    .rem_i     (partRem_q),
    .quo_i     (partQuo_q),
    .divisor_i (divisor_q),
    .rem_o     (stepRem),
    .quo_o     (stepQuo)
  );

  assign inIterWindow = (bus.STEP >= T_ITER_FIRST) && (bus.STEP <= T_ITER_LAST);

  // State register; reset clears every output and internal register at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q    <= PH_IDLE;
      partRem_q  <= '0;
      partQuo_q  <= '0;
      divisor_q  <= '0;
      err_q      <= 1'b0;
      quoOut_q   <= '0;
      remOut_q   <= '0;
      derr_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DIV8_SIGNED_EN
      signedOp_q <= 1'b0;
      negQuo_q   <= 1'b0;
      negRem_q   <= 1'b0;
`endif
    end else begin
      phase_q    <= phase_d;
      partRem_q  <= partRem_d;
      partQuo_q  <= partQuo_d;
      divisor_q  <= divisor_d;
      err_q      <= err_d;
      quoOut_q   <= quoOut_d;
      remOut_q   <= remOut_d;
      derr_q     <= derr_d;
      done_q     <= done_d;
`ifdef DIV8_SIGNED_EN
      signedOp_q <= signedOp_d;
      negQuo_q   <= negQuo_d;
      negRem_q   <= negRem_d;
`endif
    end
  end

  // Next-state logic. FIN while busy aborts without touching the results;
  // a T1 always (re)loads, discarding any operation in flight. Steps outside
  // T2..T11 end the busy phase.
  always_comb begin
    phase_d    = phase_q;
    partRem_d  = partRem_q;
    partQuo_d  = partQuo_q;
    divisor_d  = divisor_q;
    err_d      = err_q;
    quoOut_d   = quoOut_q;
    remOut_d   = remOut_q;
    derr_d     = derr_q;
    done_d     = 1'b0;
`ifdef DIV8_SIGNED_EN
    signedOp_d = signedOp_q;
    negQuo_d   = negQuo_q;
    negRem_d   = negRem_q;
`endif

    if (phase_q == PH_BUSY && bus.FIN) begin
      phase_d = PH_IDLE;
    end else if (bus.STEP == T_LOAD) begin
      phase_d   = PH_BUSY;
      partRem_d = {1'b0, dividendMag[DIVIDEND_W-1:DIVISOR_W]};
      partQuo_d = dividendMag[DIVISOR_W-1:0];
      divisor_d = divisorMag;
      // A high byte at or above the divisor means the quotient overflows 8 bits
      err_d     = (divisorMag == '0) ||
                  (dividendMag[DIVIDEND_W-1:DIVISOR_W] >= divisorMag);
`ifdef DIV8_SIGNED_EN
      signedOp_d = bus.IS_SIGNED;
      negQuo_d   = bus.IS_SIGNED &&
                   (bus.DIVIDEND[DIVIDEND_W-1] ^ bus.DIVISOR[DIVISOR_W-1]);
      negRem_d   = bus.IS_SIGNED && bus.DIVIDEND[DIVIDEND_W-1];
`endif
    end else if (phase_q == PH_BUSY) begin
      if (inIterWindow) begin
        if (!err_q) begin
          partRem_d = stepRem;
          partQuo_d = stepQuo;
        end
      end else if (bus.STEP == T_FIX) begin
`ifdef DIV8_SIGNED_EN
        if (signedOp_q && !err_q) begin
          if (partQuo_q > Q_LIMIT) begin
            err_d = 1'b1;
          end else begin
            if (negQuo_q) begin
              partQuo_d = negate8(partQuo_q);
            end
            if (negRem_q) begin
              partRem_d = {1'b0, negate8(partRem_q[DIVISOR_W-1:0])};
            end
          end
        end
`endif
      end else if (bus.STEP == T_WB) begin
        // On error AX is left as it was; only DERR reports the fault
        if (!err_q) begin
          quoOut_d = partQuo_q;
          remOut_d = partRem_q[DIVISOR_W-1:0];
        end
        derr_d = err_q;
        done_d = 1'b1;
      end else begin
        phase_d = PH_IDLE;
      end
    end
  end

  assign bus.QUO  = quoOut_q;
  assign bus.REM  = remOut_q;
  assign bus.DERR = derr_q;
  assign bus.DONE = done_q;
  assign bus.BUSY = (phase_q == PH_BUSY);

endmodule

// File: tb/tb_div8_step_datapath.sv
// tb_div8_step_datapath
// Scoreboard bench for the byte-divide datapath. A sequencer task walks
// STEP through T1..T15,T0 on negedges and pushes the expected result for
// each complete operation; a monitor pops and compares on every DONE.
// The reference model divides with plain integer arithmetic. Honours
// DIV8_SIGNED_EN the same way as the design.
module tb_div8_step_datapath;

  typedef struct {
    logic [7:0] quo;
    logic [7:0] rem;
    logic       derr;
  } exp_t;

  logic CLK;
  logic RST;

  div8_step_datapath_if bus ();

  div8_step_datapath dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  exp_t       sb[$];
  int         compared;
  int         mismatched;
  int         doneCount;
  logic [7:0] lastQuo;
  logic [7:0] lastRem;

  // Free-running clock, 10 time units per period
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard time limit so the run always ends even if stepping stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value, count it, and report a miss
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Reference model: integer divide truncating toward zero, remainder
  // taking the dividend's sign; error on zero divisor or a quotient that
  // does not fit (0..255 unsigned, -127..+127 signed). On error the
  // architectural result keeps its previous value.
  function automatic exp_t refModel(input logic [15:0] dvd, input logic [7:0] dsr,
                                    input logic sgn);
    exp_t e;
    int   a, b, q, r;
    bit   signedOp;
    bit   err;
`ifdef DIV8_SIGNED_EN
    signedOp = sgn;
`else
    signedOp = 1'b0;
    if (sgn) signedOp = 1'b0;
`endif
    if (signedOp) begin
      a = int'($signed(dvd));
      b = int'($signed(dsr));
    end else begin
      a = int'({16'd0, dvd});
      b = int'({24'd0, dsr});
    end
    q = 0;
    r = 0;
    if (b == 0) begin
      err = 1'b1;
    end else begin
      q   = a / b;
      r   = a % b;
      err = signedOp ? (q > 127 || q < -127) : (q > 255);
    end
    if (!err) begin
      lastQuo = q[7:0];
      lastRem = r[7:0];
    end
    e.quo  = lastQuo;
    e.rem  = lastRem;
    e.derr = err;
    return e;
  endfunction

  // Monitor: every DONE must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (!RST && bus.DONE === 1'b1) begin
      doneCount++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedDone: got DONE=1, required no pending result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("QUO",  {8'd0, bus.QUO},  {8'd0, e.quo});
        checkOutput("REM",  {8'd0, bus.REM},  {8'd0, e.rem});
        checkOutput("DERR", {15'd0, bus.DERR}, {15'd0, e.derr});
      end
    end
  end

  // Drive one operation through the step sequence. abortStep raises FIN at
  // that step, rstStep pulses RST during that step, stopAfter ends the run
  // early (for restart tests); any of them suppresses the expectation.
  task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dsr,
                               input logic sgn, input int abortStep,
                               input int rstStep, input int stopAfter);
    bit   normal;
    int   prev;
    int   doneBefore;
    exp_t e;
    normal     = (abortStep < 0) && (rstStep < 0) && (stopAfter < 0);
    prev       = -1;
    doneBefore = doneCount;
    if (normal) begin
      e = refModel(dvd, dsr, sgn);
      sb.push_back(e);
    end
    for (int k = 0; k < 16; k++) begin
      int s;
      s = (k + 1) % 16;
      if (stopAfter >= 0 && s > stopAfter) break;
      @(negedge CLK);
      if (RST) RST = 1'b0;
      if (normal && prev == 1) checkOutput("busyAfterLoad", {15'd0, bus.BUSY}, 16'd1);
      if (normal && prev == 11) checkOutput("busyInDone", {15'd0, bus.BUSY}, 16'd1);
      if (normal && prev == 12) checkOutput("busyAfterWb", {15'd0, bus.BUSY}, 16'd0);
      if (abortStep >= 0 && prev == abortStep)
        checkOutput("busyAfterAbort", {15'd0, bus.BUSY}, 16'd0);
      bus.STEP = s[3:0];
      bus.FIN  = (s == 0) || (s == abortStep);
      if (s == 1) begin
        bus.DIVIDEND  = dvd;
        bus.DIVISOR   = dsr;
        bus.IS_SIGNED = sgn;
      end
      if (s == rstStep) begin
        #2 RST = 1'b1;
        #1;
        checkOutput("rstQUO",  {8'd0, bus.QUO},  16'd0);
        checkOutput("rstREM",  {8'd0, bus.REM},  16'd0);
        checkOutput("rstDERR", {15'd0, bus.DERR}, 16'd0);
        checkOutput("rstBUSY", {15'd0, bus.BUSY}, 16'd0);
        lastQuo = 8'h00;
        lastRem = 8'h00;
      end
      prev = s;
    end
    if (!normal && stopAfter < 0) begin
      @(negedge CLK);
      checkOutput("noDoneOnAbort", doneCount[15:0], doneBefore[15:0]);
      checkOutput("keptQUO", {8'd0, bus.QUO}, {8'd0, lastQuo});
      checkOutput("keptREM", {8'd0, bus.REM}, {8'd0, lastRem});
    end
  endtask

  // Main sequence: reset, directed vectors, abort/restart cases, random run
  initial begin
    logic [15:0] dvd;
    logic [7:0]  dsr;
    logic        sgn;
    compared      = 0;
    mismatched    = 0;
    doneCount     = 0;
    lastQuo       = 8'h00;
    lastRem       = 8'h00;
    RST           = 1'b1;
    bus.STEP      = 4'd0;
    bus.FIN       = 1'b1;
    bus.IS_SIGNED = 1'b0;
    bus.DIVIDEND  = 16'h0000;
    bus.DIVISOR   = 8'h00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("resetQUO",  {8'd0, bus.QUO},  16'd0);
    checkOutput("resetREM",  {8'd0, bus.REM},  16'd0);
    checkOutput("resetDERR", {15'd0, bus.DERR}, 16'd0);
    checkOutput("resetDONE", {15'd0, bus.DONE}, 16'd0);
    checkOutput("resetBUSY", {15'd0, bus.BUSY}, 16'd0);

    applyStimulus(16'h0064, 8'h07, 1'b0, -1, -1, -1);
    applyStimulus(16'h1234, 8'h00, 1'b0, -1, -1, -1);
    applyStimulus(16'h0200, 8'h02, 1'b0, -1, -1, -1);
    applyStimulus(16'hFF9C, 8'h07, 1'b1, -1, -1, -1);
    applyStimulus(16'h0080, 8'h01, 1'b1, -1, -1, -1);
    applyStimulus(16'hFF81, 8'h01, 1'b1, -1, -1, -1);
    applyStimulus(16'h0064, 8'h07, 1'b0, -1, 5, -1);
    applyStimulus(16'h0064, 8'h07, 1'b0, -1, -1, -1);
    applyStimulus(16'h0123, 8'h45, 1'b0, 6, -1, -1);
    applyStimulus(16'h00FF, 8'h10, 1'b0, -1, -1, 4);
    applyStimulus(16'h00C8, 8'h0B, 1'b0, -1, -1, -1);

    for (int i = 0; i < 40; i++) begin
      dsr = 8'($urandom_range(0, 255));
      dvd = 16'($urandom_range(0, 65535));
      sgn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0 && dsr != 8'h00)
        dvd[15:8] = 8'($urandom_range(0, int'(dsr) - 1));
      applyStimulus(dvd, dsr, sgn, -1, -1, -1);
    end

    repeat (3) @(negedge CLK);
    checkOutput("scoreboardDrained", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/div8_step_datapath.md
# div8_step_datapath

Restoring-division datapath for the 8088 ALU byte divide (DIV r/m8 / IDIV r/m8). It divides a 16-bit dividend by an 8-bit divisor into an 8-bit quotient and an 8-bit remainder, and flags a divide error. The block is the responder to the divide sequencer. That sequencer advances a 4-bit step index T0..T15 on the falling clock edge and raises FIN in T0. This block consumes the step index on the rising edge and performs exactly one datapath action per step.

## Interface
Parameters: none.
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset, asynchronous, active-high.
- STEP  in  4  sequencer step index; stable around posedge.
- FIN  in  1  sequencer idle flag; high only in T0.
- IS_SIGNED  in  1  1 = IDIV, 0 = DIV; sampled at T1.
- DIVIDEND  in  16  AX operand; sampled at T1.
- DIVISOR  in  8  r/m8 operand; sampled at T1.
- QUO  out  8  quotient (AL); reset 0x00.
- REM  out  8  remainder (AH); reset 0x00.
- DERR  out  1  divide error (INT 0 request); reset 0; valid with DONE.
- DONE  out  1  one-cycle completion pulse; reset 0.
- BUSY  out  1  high from the T1 load to the T11 writeback inclusive; reset 0.

## Operation
Internal state:
- R: 9-bit partial remainder.
- Q: 8-bit partial quotient.
- Flags: error, negate-quotient, negate-remainder.

Actions per step:
- T1 load:
  - Capture the operands.
  - Signed mode: convert the dividend and divisor to magnitudes, then set negq = sign(dividend) XOR sign(divisor) and negr = sign(dividend).
  - R = {0, magnitude dividend[15:8]}, Q = magnitude dividend[7:0].
  - Set error if the divisor is 0x00.
  - Set error if magnitude dividend[15:8] >= magnitude divisor (the quotient would need more than 8 bits).
- T2..T9, eight iterations, skipped when error is set:
  - T = {R[7:0], Q[7]}, then Q = Q << 1.
  - If T >= {0, divisor}: R = T − divisor and Q[0] = 1.
  - Otherwise: R = T.
- T10 fixup:
  - Signed mode: set error if Q > 127. The accepted quotient range is −127..+127.
  - Otherwise apply negq to Q and negr to R[7:0] (two's complement).
- T11 writeback:
  - If error is clear, update QUO = Q and REM = R[7:0].
  - DERR = error.
  - DONE = 1 for this single cycle.
  - If error is set, QUO and REM keep their previous values, matching the 8088 rule that AX is unchanged on a divide error.
- T12..T15 and T0: hold. QUO, REM and DERR remain stable until the next T11.

Boundary conditions:
- FIN seen high while BUSY: abort. Clear BUSY and do not pulse DONE. QUO, REM and DERR are unchanged.
- STEP jumps backwards or repeats T1: the new T1 reloads, and the previous operation is discarded.
- RST at any step: every output and every internal register returns to its reset value immediately.
- Division truncates toward zero. The remainder takes the sign of the dividend.

## Timing
- The sequencer changes STEP on negedge. This block samples STEP on the following posedge, half a cycle later.
- Operands must be stable from sequencer ENA until the posedge in T1.
- Latency: the result is visible after the posedge in T11, which is 11 posedges after the T1 load posedge counting the load edge as 1, i.e. 10 clocks after load.
- DONE is high for exactly the one cycle between the T11 posedge and the T12 posedge.

## Configuration
- DIV8_SIGNED_EN defined:
  - IDIV is supported: magnitude conversion, sign fixup, and the ±127 quotient check.
- DIV8_SIGNED_EN undefined:
  - IS_SIGNED is ignored and treated as 0.
  - All operations are unsigned.
  - No negation logic is compiled in.

## Structure
- Shared package div8_pkg holds:
  - the step constants T_LOAD=1, T_ITER_FIRST=2, T_ITER_LAST=9, T_FIX=10, T_WB=11;
  - the operand widths (16/8/9);
  - the signed quotient limit (127).
- One combinational sub-module, div8_restore_step: inputs R[8:0], Q[7:0] and the divisor; outputs the next R and the next Q for one restoring iteration. It is instantiated once and reused at every iteration step.

## Test plan
- Unsigned 0x0064 / 0x07 → QUO=0x0E, REM=0x02, DERR=0. DONE pulses once, at T11.
- Next run 0x1234 / 0x00 → DERR=1. QUO and REM still read 0x0E and 0x02.
- Unsigned 0x0200 / 0x02 → DERR=1, because the high byte 0x02 is >= 0x02.
- With DIV8_SIGNED_EN: IDIV 0xFF9C / 0x07 → QUO=0xF2, REM=0xFE.
- Same stimulus without DIV8_SIGNED_EN: unsigned, DERR=1.
- With DIV8_SIGNED_EN:
  - IDIV 0x0080 / 0x01 → DERR=1 (quotient 128 is out of range).
  - IDIV 0xFF81 / 0x01 → QUO=0x81, REM=0x00, DERR=0.
- Abort cases:
  - RST pulsed at T5 → all outputs 0 immediately, no DONE.
  - Separately, FIN forced high at T6 → BUSY=0, no DONE, previous results retained.
